// File: rtl/dcache_pkg.sv
// Shared types, constants and width helpers for the data cache controller.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MEM_RD   = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_MEM_WR   = 3'd4,
        S_RESP     = 3'd5,
        S_FLUSH    = 3'd6
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps of x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets);
        return addr_w - 2 - $clog2(sets);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used for pseudo-random way replacement.
module dcache_lfsr
    import dcache_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] out
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next-state: shift left, feed back the XOR of the tapped bits
    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/dcache_controller.sv
// 4-way write-through, no-write-allocate data cache controller: lookup, miss FSM,
// flush sequencing and hit/miss statistics.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_we,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int INDEX_W = index_w(SETS);
    localparam int TAG_W   = tag_w(ADDR_WIDTH, SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WADDR_W = ADDR_WIDTH - 2;

    state_e                  state_q, state_d;
    logic [WADDR_W-1:0]      addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [INDEX_W-1:0]      set_cnt_q, set_cnt_d;
    logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    mem_valid_q, mem_valid_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    flush_done_q, flush_done_d;
    logic [31:0]             hit_q, hit_d;
    logic [31:0]             miss_q, miss_d;

    logic [TAG_W-1:0]        tag_mem [SETS][WAYS];
    logic [DATA_WIDTH-1:0]   data_mem [SETS][WAYS];

    logic [7:0]              lfsr_s;
    logic [INDEX_W-1:0]      idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic [WAYS-1:0]         hit_vec_s;
    logic                    hit_s;
    logic [WAY_W-1:0]        hit_way_s;
    logic [DATA_WIDTH-1:0]   hit_data_s;
    logic [WAY_W-1:0]        victim_s;
    logic                    data_we_s;
    logic                    fill_s;
    logic                    flush_clr_s;
    logic [WAY_W-1:0]        data_way_s;
    logic [DATA_WIDTH-1:0]   data_wdata_s;
    logic                    last_set_s;
    logic                    unused_s;

    dcache_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .out   (lfsr_s)
    );

    assign idx_s      = addr_q[INDEX_W-1:0];
    assign tag_s      = addr_q[WADDR_W-1 -: TAG_W];
    assign last_set_s = (set_cnt_q == INDEX_W'(SETS - 1));
    assign unused_s   = ^{cpu_req_addr[1:0], lfsr_s[7:WAY_W]};

    // Tag compare and victim choice; walking ways downward lets the lowest index win
    always_comb begin
        hit_vec_s  = '0;
        hit_way_s  = '0;
        hit_data_s = '0;
        victim_s   = lfsr_s[WAY_W-1:0];
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec_s[w] = valid_q[idx_s][w] && (tag_mem[idx_s][w] == tag_s);
            hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
            hit_data_s   = hit_vec_s[w] ? data_mem[idx_s][w] : hit_data_s;
            victim_s     = !valid_q[idx_s][w] ? WAY_W'(w) : victim_s;
        end
        hit_s = |hit_vec_s;
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        set_cnt_d    = set_cnt_q;
        rdata_d      = rdata_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        data_we_s    = 1'b0;
        fill_s       = 1'b0;
        flush_clr_s  = 1'b0;
        data_way_s   = hit_way_s;
        data_wdata_s = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d   = S_FLUSH;
                    set_cnt_d = '0;
                end else if (cpu_req_valid) begin
                    state_d = S_LOOKUP;
                    addr_d  = cpu_req_addr[ADDR_WIDTH-1:2];
                    we_d    = cpu_req_we;
                    wdata_d = cpu_req_wdata;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_s) begin
                    hit_d = sat_inc(hit_q);
                end else begin
                    miss_d = sat_inc(miss_q);
                end
                // Memory request fields are frozen here and held until the handshake
                mem_addr_d  = {addr_q, 2'b00};
                mem_we_d    = we_q;
                mem_wdata_d = we_q ? wdata_q : '0;
                if (we_q) begin
                    state_d   = S_MEM_WR;
                    rdata_d   = '0;
                    data_we_s = hit_s;
                end else if (hit_s) begin
                    state_d = S_RESP;
                    rdata_d = hit_data_s;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                state_d = mem_req_ready ? S_MEM_WAIT : S_MEM_RD;
            end
            S_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    state_d      = S_RESP;
                    fill_s       = 1'b1;
                    data_we_s    = 1'b1;
                    data_way_s   = victim_s;
                    data_wdata_s = mem_resp_rdata;
                    rdata_d      = mem_resp_rdata;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WR: begin
                state_d = mem_req_ready ? S_RESP : S_MEM_WR;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                flush_clr_s = 1'b1;
                set_cnt_d   = set_cnt_q + INDEX_W'(1);
                state_d     = last_set_s ? S_IDLE : S_FLUSH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = valid_q;
        if (flush_clr_s) begin
            valid_d[set_cnt_q] = '0;
        end else if (fill_s) begin
            valid_d[idx_s][data_way_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end

        resp_valid_d = (state_d == S_RESP);
        mem_valid_d  = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
        flush_done_d = (state_q == S_FLUSH) && last_set_s;
    end

    // Tag/data arrays carry no reset; only the valid bits qualify them
    always_ff @(posedge clk) begin
        if (data_we_s) begin
            data_mem[idx_s][data_way_s] <= data_wdata_s;
        end
        if (fill_s) begin
            tag_mem[idx_s][data_way_s] <= tag_s;
        end
    end

    // Control state, valid bits and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            set_cnt_q    <= '0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            flush_done_q <= 1'b0;
            hit_q        <= 32'd0;
            miss_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            set_cnt_q    <= set_cnt_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            flush_done_q <= flush_done_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign cpu_req_ready  = (state_q == S_IDLE) && !flush_req;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = rdata_q;
    assign mem_req_valid  = mem_valid_q;
    assign mem_req_we     = mem_we_q;
    assign mem_req_addr   = mem_addr_q;
    assign mem_req_wdata  = mem_wdata_q;
    assign flush_done     = flush_done_q;
    assign hit_count      = hit_q;
    assign miss_count     = miss_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: memory responder model, response scoreboard,
// independent LFSR model for replacement prediction.
module tb_dcache_controller;

    logic        clk;
    logic        rst_n;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        flush_req;
    logic        flush_done;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    dcache_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cnt = 0;
    int last_resp_cyc = 0;
    int flush_done_cnt = 0;
    int last_fd_cyc = 0;
    int reads = 0;
    int writes = 0;
    int rd_latency = 3;
    int rd_pending = 0;
    int stall_left = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    logic [31:0] rd_data;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic [31:0] held_addr;
    logic [31:0] held_wdata;
    logic        was_stalled = 1'b0;
    logic [7:0]  lfsr_m;
    logic [7:0]  fill_lfsr;
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] sb_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR for x^8+x^6+x^5+x^4+1, seeded 0xA5
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 8'hA5;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        else return a ^ 32'h5EED_0000;
    endfunction

    // Response monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (cpu_resp_valid) begin
            resp_cnt++;
            last_resp_cyc = cyc;
            check("sb_depth", sb_q.size(), 32'd1);
            if (sb_q.size() > 0) check("resp_rdata", cpu_resp_rdata, sb_q.pop_front());
        end
        if (flush_done) begin
            flush_done_cnt++;
            last_fd_cyc = cyc;
        end
    end

    // Memory model: programmable ready stall, fixed read latency, write-through storage
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (rd_pending > 0) begin
                rd_pending--;
                if (rd_pending == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = rd_data;
                    fill_lfsr      = lfsr_m;
                end
            end
            if (mem_req_valid && rst_n) begin
                if (was_stalled) begin
                    check("stall_addr_stable", mem_req_addr, held_addr);
                    check("stall_wdata_stable", mem_req_wdata, held_wdata);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    mem_req_ready = 1'b0;
                    was_stalled   = 1'b1;
                    held_addr     = mem_req_addr;
                    held_wdata    = mem_req_wdata;
                end else begin
                    mem_req_ready = 1'b1;
                    was_stalled   = 1'b0;
                    if (mem_req_we) begin
                        writes++;
                        last_wr_addr = mem_req_addr;
                        last_wr_data = mem_req_wdata;
                        mem_m[mem_req_addr] = mem_req_wdata;
                    end else begin
                        reads++;
                        rd_data    = mem_read(mem_req_addr);
                        rd_pending = rd_latency;
                    end
                end
            end else begin
                mem_req_ready = 1'b0;
                was_stalled   = 1'b0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_is_hit, input logic wait_resp, output int lat);
        int n0;
        int b;
        int acc;
        lat = 0;
        if (exp_is_hit) exp_hit++;
        else exp_miss++;
        sb_q.push_back(we ? 32'd0 : mem_read(addr));
        n0 = resp_cnt;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        #1;
        b = 0;
        while (!cpu_req_ready && b < 50) begin
            @(negedge clk);
            #1;
            b++;
        end
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        acc = cyc;
        if (wait_resp) begin
            b = 0;
            while (resp_cnt == n0 && b < 200) begin
                @(negedge clk);
                #1;
                b++;
            end
            check("resp_arrived", resp_cnt, n0 + 1);
            lat = last_resp_cyc - acc + 1;
        end
    endtask

    initial begin
        int lat;
        int b;
        int n0;
        int r0;
        int fd0;
        int fstart;
        int v;
        logic [31:0] a5 [5];

        rst_n = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we = 1'b0;
        cpu_req_addr = 32'd0;
        cpu_req_wdata = 32'd0;
        flush_req = 1'b0;
        mem_m[32'h0000_1000] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        check("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        check("rst_rdata", cpu_resp_rdata, 32'd0);
        check("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_mem_addr", mem_req_addr, 32'd0);
        check("rst_flush_done", {31'd0, flush_done}, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        check("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Load miss then reload of the same word
        rd_latency = 3;
        do_req(1'b0, 32'h0000_1000, 32'd0, 1'b0, 1'b1, lat);
        do_req(1'b0, 32'h0000_1000, 32'd0, 1'b1, 1'b1, lat);
        check("hit_latency", lat, 32'd2);
        check("t1_reads", reads, 32'd1);
        check("t1_hits", hit_count, exp_hit);
        check("t1_misses", miss_count, exp_miss);

        // Store miss: written through, not allocated
        do_req(1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0, 1'b1, lat);
        check("t2_writes", writes, 32'd1);
        check("t2_wr_addr", last_wr_addr, 32'h0000_0100);
        check("t2_wr_data", last_wr_data, 32'h1234_5678);
        do_req(1'b0, 32'h0000_0100, 32'd0, 1'b0, 1'b1, lat);
        check("t2_reads", reads, 32'd2);
        // Store hit updates the cached word
        do_req(1'b1, 32'h0000_1003, 32'h1111_2222, 1'b1, 1'b1, lat);
        do_req(1'b0, 32'h0000_1000, 32'd0, 1'b1, 1'b1, lat);
        check("t2_reads_after_hit", reads, 32'd2);
        check("t2_hits", hit_count, exp_hit);
        check("t2_misses", miss_count, exp_miss);

        // Store with memory ready held off for 10 cycles
        stall_left = 10;
        do_req(1'b1, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 1'b1, lat);
        check("stall_store_latency", lat, 32'd13);
        check("stall_wr_addr", last_wr_addr, 32'h0000_0204);
        check("stall_wr_data", last_wr_data, 32'hCAFE_F00D);

        // Flush wins over a simultaneous request; the request then misses
        exp_miss++;
        sb_q.push_back(mem_read(32'h0000_1000));
        n0 = resp_cnt;
        fd0 = flush_done_cnt;
        @(negedge clk);
        flush_req = 1'b1;
        cpu_req_valid = 1'b1;
        cpu_req_we = 1'b0;
        cpu_req_addr = 32'h0000_1000;
        #1;
        check("flush_blocks_ready", {31'd0, cpu_req_ready}, 32'd0);
        @(posedge clk);
        #1;
        fstart = cyc;
        flush_req = 1'b0;
        b = 0;
        while (flush_done_cnt == fd0 && b < 200) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("flush_cycles", last_fd_cyc - fstart, 32'd64);
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        b = 0;
        while (resp_cnt == n0 && b < 200) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("flush_req_resp", resp_cnt, n0 + 1);
        check("flush_done_once", flush_done_cnt, fd0 + 1);
        check("flush_misses", miss_count, exp_miss);

        // Reset while waiting for read data; the late response must be ignored
        rd_latency = 6;
        r0 = reads;
        do_req(1'b0, 32'h0000_3008, 32'd0, 1'b0, 1'b0, lat);
        b = 0;
        while (reads == r0 && b < 50) begin
            @(negedge clk);
            #1;
            b++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        exp_hit = 0;
        exp_miss = 0;
        n0 = resp_cnt;
        @(negedge clk);
        #1;
        check("midrst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
        check("midrst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        check("midrst_misses", miss_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("stray_resp_ignored", resp_cnt, n0);
        rd_latency = 2;
        do_req(1'b0, 32'h0000_3008, 32'd0, 1'b0, 1'b1, lat);
        check("postrst_misses", miss_count, 32'd1);
        check("postrst_hits", hit_count, 32'd0);

        // Five distinct tags in set 0: fill ways 0..3, then random eviction
        for (int k = 0; k < 5; k++) begin
            a5[k] = (k + 1) << 16;
            do_req(1'b0, a5[k], 32'd0, 1'b0, 1'b1, lat);
        end
        v = int'(fill_lfsr[1:0]);
        do_req(1'b0, a5[4], 32'd0, 1'b1, 1'b1, lat);
        do_req(1'b0, a5[(v + 1) % 4], 32'd0, 1'b1, 1'b1, lat);
        do_req(1'b0, a5[v], 32'd0, 1'b0, 1'b1, lat);
        check("evict_hits", hit_count, exp_hit);
        check("evict_misses", miss_count, exp_miss);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
